// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq
// Description : Registered one-hot position decoder with step and
//               auto-sequencing at a programmable dwell.
//               Optional DECODER_SEQ_ONEHOT_CHECK_EN adds a sticky err output.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4,
    parameter int WRAP    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  step,
    input  logic                  run,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] q,
    output logic [SEL_W-1:0]      pos,
    output logic                  busy,
    output logic                  done
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int N = 2 ** SEL_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   pos_q, pos_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic [N-1:0]       q_q, q_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        dwell_lat_d = dwell_lat_q;
        done_d      = 1'b0;

        if (clr) begin
            state_d = S_IDLE;
            pos_d   = '0;
            cnt_d   = '0;
            done_d  = (state_q == S_RUN);
        end else if (load) begin
            state_d = S_HOLD;
            pos_d   = sel;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (run) begin
                        state_d     = S_RUN;
                        cnt_d       = dwell;
                        dwell_lat_d = dwell;
                    end else if (step) begin
                        pos_d = pos_q + SEL_W'(1);
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        if ((pos_q == '1) && (WRAP == 0)) begin
                            state_d = S_HOLD;
                            done_d  = 1'b1;
                        end else begin
                            pos_d = pos_q + SEL_W'(1);
                            cnt_d = dwell_lat_q;
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Position 0 is the MSB of q, so the bit index is the inverted position.
        q_d = '0;
        if (state_d != S_IDLE) begin
            q_d[~pos_d] = 1'b1;
        end
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            cnt_q       <= '0;
            dwell_lat_q <= '0;
            q_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            dwell_lat_q <= dwell_lat_d;
            q_q         <= q_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign q    = q_q;
    assign pos  = pos_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    logic err_q, err_d;
    logic onehot_bad;

    always_comb begin
        if (state_q == S_IDLE) begin
            onehot_bad = (q_q != '0);
        end else begin
            onehot_bad = (q_q == '0) || ((q_q & (q_q - N'(1))) != '0);
        end
        err_d = clr ? 1'b0 : (err_q | onehot_bad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!onehot_bad);
        end
    end

    assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_seq
// Description : Directed bench for decoder_seq, WRAP=0 and WRAP=1 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       reset, clr, load, step, run;
    logic [2:0] sel;
    logic [3:0] dwell;
    logic [7:0] q0, q1;
    logic [2:0] pos0, pos1;
    logic       busy0, busy1, done0, done1;
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    logic       err0, err1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_seq #(.SEL_W(3), .DWELL_W(4), .WRAP(0)) u_nowrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .sel(sel),
        .step(step), .run(run), .dwell(dwell),
        .q(q0), .pos(pos0), .busy(busy0), .done(done0)
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
        , .err(err0)
`endif
    );

    decoder_seq #(.SEL_W(3), .DWELL_W(4), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .sel(sel),
        .step(step), .run(run), .dwell(dwell),
        .q(q1), .pos(pos1), .busy(busy1), .done(done1)
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
        , .err(err1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_err();
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
        check("err_nowrap", 32'(err0), 32'd0);
        check("err_wrap", 32'(err1), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; load = 1'b0; step = 1'b0; run = 1'b0;
        sel = 3'd0; dwell = 4'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_q", 32'(q0), 32'h00);
        check("rst_pos", 32'(pos0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check_err();

        // IDLE ignores step and run
        step = 1'b1; run = 1'b1; tick(); step = 1'b0; run = 1'b0;
        check("idle_ignore_q", 32'(q0), 32'h00);
        check("idle_ignore_busy", 32'(busy0), 32'd0);

        load = 1'b1; sel = 3'd5; tick(); load = 1'b0;
        check("load5_q", 32'(q0), 32'h04);
        check("load5_pos", 32'(pos0), 32'd5);
        check("load5_busy", 32'(busy0), 32'd0);

        load = 1'b1; sel = 3'd7; tick(); load = 1'b0;
        check("load7_q", 32'(q0), 32'h01);
        step = 1'b1; tick(); step = 1'b0;
        check("step_wrap_q", 32'(q0), 32'h80);
        check("step_wrap_pos", 32'(pos0), 32'd0);
        step = 1'b1; tick(); step = 1'b0;
        check("step1_q", 32'(q0), 32'h40);

        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_hold_q", 32'(q0), 32'h00);
        check("clr_hold_done", 32'(done0), 32'd0);

        // run from 6 with dwell=2; dwell changes after run must be ignored
        load = 1'b1; sel = 3'd6; tick(); load = 1'b0;
        run = 1'b1; dwell = 4'd2; tick(); run = 1'b0; dwell = 4'd0;
        for (int i = 0; i < 3; i++) begin
            check("run6_pos", 32'(pos0), 32'd6);
            check("run6_q", 32'(q0), 32'h02);
            check("run6_busy", 32'(busy0), 32'd1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("run7_pos", 32'(pos0), 32'd7);
            check("run7_busy", 32'(busy0), 32'd1);
            check("run7_done", 32'(done0), 32'd0);
            tick();
        end
        check("end_done", 32'(done0), 32'd1);
        check("end_busy", 32'(busy0), 32'd0);
        check("end_q", 32'(q0), 32'h01);
        check("end_pos", 32'(pos0), 32'd7);
        check("wrap_pos0", 32'(pos1), 32'd0);
        check("wrap_busy", 32'(busy1), 32'd1);
        check("wrap_done", 32'(done1), 32'd0);
        tick();
        check("end_done_pulse", 32'(done0), 32'd0);
        check("end_q_held", 32'(q0), 32'h01);
        check("end_busy_low", 32'(busy0), 32'd0);

        // load aborts the still-running WRAP=1 instance without done
        load = 1'b1; sel = 3'd6; tick(); load = 1'b0;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_done", 32'(done1), 32'd0);
        check("abort_q", 32'(q1), 32'h02);

        run = 1'b1; dwell = 4'd0; tick(); run = 1'b0;
        check("d0_pos6", 32'(pos1), 32'd6);
        check("d0_busy", 32'(busy1), 32'd1);
        tick();
        check("d0_pos7", 32'(pos1), 32'd7);
        check("d0_q7", 32'(q1), 32'h01);
        tick();
        check("d0_pos0", 32'(pos1), 32'd0);
        check("d0_q0", 32'(q1), 32'h80);
        check("d0_wrap_done", 32'(done1), 32'd0);
        check("d0_nowrap_done", 32'(done0), 32'd1);
        tick();
        check("d0_pos1", 32'(pos1), 32'd1);
        check("d0_busy1", 32'(busy1), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_run_q", 32'(q1), 32'h00);
        check("clr_run_done", 32'(done1), 32'd1);
        check("clr_run_busy", 32'(busy1), 32'd0);
        check("clr_hold_done2", 32'(done0), 32'd0);
        tick();
        check("clr_run_pulse", 32'(done1), 32'd0);

        // load wins over step while running at position 3
        load = 1'b1; sel = 3'd3; tick(); load = 1'b0;
        run = 1'b1; dwell = 4'd5; tick(); run = 1'b0;
        check("p3_busy", 32'(busy1), 32'd1);
        load = 1'b1; step = 1'b1; sel = 3'd1; tick(); load = 1'b0; step = 1'b0;
        check("ldstep_q", 32'(q1), 32'h40);
        check("ldstep_pos", 32'(pos1), 32'd1);
        check("ldstep_busy", 32'(busy1), 32'd0);
        check("ldstep_done", 32'(done1), 32'd0);
        tick();
        check("ldstep_hold", 32'(pos1), 32'd1);
        check_err();

        // reset mid-run
        load = 1'b1; sel = 3'd2; tick(); load = 1'b0;
        run = 1'b1; dwell = 4'd0; tick(); run = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rr_q", 32'(q1), 32'h00);
        check("rr_pos", 32'(pos1), 32'd0);
        check("rr_busy", 32'(busy1), 32'd0);
        check("rr_done", 32'(done1), 32'd0);
        check_err();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
